// File: rtl/mux42_input_conditioner_if.sv
// Bundle of raw board inputs and conditioned mux-facing outputs for the
// 4-to-1, 2-bit multiplexer front end.
interface mux42_input_conditioner_if;
  logic [9:0] sw_in;
  logic       btn_in;
  logic       mode_in;
  logic [7:0] din_out;
  logic [1:0] sel_out;
  logic [1:0] step_cnt;
  logic       changed;

  modport master (
    output sw_in, btn_in, mode_in,
    input  din_out, sel_out, step_cnt, changed
  );

  modport slave (
    input  sw_in, btn_in, mode_in,
    output din_out, sel_out, step_cnt, changed
  );
endinterface

// File: rtl/mux42_input_conditioner.sv
// Synchronises and debounces the board switches, step button and mode switch,
// then derives mux data, mux select, a stepped-select counter and a change strobe.
module mux42_input_conditioner #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  mux42_input_conditioner_if.slave          bus
);

  localparam int N_LINES = 12;
  localparam int BTN_IDX = 10;
  localparam int MODE_IDX = 11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [N_LINES-1:0] raw_lines;
  logic [N_LINES-1:0] sync1_reg;
  logic [N_LINES-1:0] sync2_reg;
  logic [N_LINES-1:0] db_lines;

  logic [1:0] step_cnt_reg;
  logic       btn_prev_reg;
  logic [9:0] prev_reg;
  logic       changed_reg;

  logic [1:0] sel_next;
  logic [9:0] outs_now;
  logic       btn_rise;

  // Line order: sw[9:0], then btn, then mode.
  assign raw_lines = {bus.mode_in, bus.btn_in, bus.sw_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_lines;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_LINES; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;
      logic             db_reg;

      // The debounced value only moves after STABLE_CYCLES consecutive
      // disagreeing samples; any agreement restarts the run from zero.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
          db_reg  <= 1'b0;
        end else if (sync2_reg[gi] == db_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          db_reg  <= sync2_reg[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign db_lines[gi] = db_reg;
    end
  endgenerate

  assign btn_rise = db_lines[BTN_IDX] & ~btn_prev_reg;

  // Counter advances whatever the mode so its value survives mode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_reg <= 1'b0;
      step_cnt_reg <= 2'd0;
    end else begin
      btn_prev_reg <= db_lines[BTN_IDX];
      if (btn_rise) begin
        step_cnt_reg <= step_cnt_reg + 2'd1;
      end
    end
  end

  assign sel_next = db_lines[MODE_IDX] ? step_cnt_reg : db_lines[1:0];
  assign outs_now = {db_lines[9:2], sel_next};

  // prev starts at zero, matching the all-zero outputs out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg    <= '0;
      changed_reg <= 1'b0;
    end else begin
      prev_reg    <= outs_now;
      changed_reg <= (outs_now != prev_reg);
    end
  end

  assign bus.din_out  = db_lines[9:2];
  assign bus.sel_out  = sel_next;
  assign bus.step_cnt = step_cnt_reg;
  assign bus.changed  = changed_reg;

endmodule
